// File: rtl/ram_model.sv
// Single-port word-addressed RAM with a fixed, pipelined read latency.
// Read data is presented one cycle ahead of its ack pulse.
module ram_model #(
    parameter int ADDR_SIZE = 13,
    parameter int WORD_SIZE = 16,
    parameter int LATENCY   = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 ram_clk,
    input  logic                 ram_rst,
    input  logic [ADDR_SIZE-1:0] ram_addr,
    input  logic [WORD_SIZE-1:0] ram_wdata,
    input  logic                 ram_avalid,
    input  logic                 ram_rnw,
    output logic [WORD_SIZE-1:0] ram_rdata,
    output logic                 ram_ack,
    output logic [CNT_WIDTH-1:0] rd_count,
    output logic [CNT_WIDTH-1:0] wr_count
);
    localparam int DEPTH = 1 << ADDR_SIZE;

    if (LATENCY < 2 || LATENCY > 16) begin : g_bad_latency
        $error("ram_model: LATENCY=%0d is outside the legal range 2..16", LATENCY);
    end

    logic [WORD_SIZE-1:0] mem [DEPTH];

    logic                 rd_en;
    logic                 wr_en;

    logic [LATENCY-1:0]   valid_q;
    logic [LATENCY-1:0]   valid_d;
    logic [WORD_SIZE-1:0] data_q [LATENCY-1];
    logic [WORD_SIZE-1:0] data_d [LATENCY-1];

    logic [WORD_SIZE-1:0] rdata_q;
    logic [WORD_SIZE-1:0] rdata_d;
    logic                 ack_q;
    logic                 ack_d;
    logic [CNT_WIDTH-1:0] rd_count_q;
    logic [CNT_WIDTH-1:0] rd_count_d;
    logic [CNT_WIDTH-1:0] wr_count_q;
    logic [CNT_WIDTH-1:0] wr_count_d;

    // A request in a reset cycle is dropped, so a write there must not reach memory.
    assign rd_en = ram_avalid &  ram_rnw & ~ram_rst;
    assign wr_en = ram_avalid & ~ram_rnw & ~ram_rst;

    always_comb begin
        valid_d    = {valid_q[LATENCY-2:0], rd_en};
        data_d     = data_q;
        data_d[0]  = mem[ram_addr];
        for (int i = 1; i < LATENCY - 1; i++) begin
            data_d[i] = data_q[i-1];
        end
        rdata_d    = rdata_q;
        if (valid_q[LATENCY-2]) begin
            rdata_d = data_q[LATENCY-2];
        end
        ack_d      = valid_q[LATENCY-1];
        rd_count_d = rd_count_q + {{(CNT_WIDTH-1){1'b0}}, rd_en};
        wr_count_d = wr_count_q + {{(CNT_WIDTH-1){1'b0}}, wr_en};
    end

    always_ff @(posedge ram_clk) begin
        if (ram_rst) begin
            valid_q    <= '0;
            rdata_q    <= '0;
            ack_q      <= 1'b0;
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else begin
            valid_q    <= valid_d;
            rdata_q    <= rdata_d;
            ack_q      <= ack_d;
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    // Data stages carry no reset; only the valid bits decide whether a word is used.
    always_ff @(posedge ram_clk) begin
        for (int i = 0; i < LATENCY - 1; i++) begin
            data_q[i] <= data_d[i];
        end
    end

    always_ff @(posedge ram_clk) begin
        if (wr_en) begin
            mem[ram_addr] <= ram_wdata;
        end
    end

    assign ram_rdata = rdata_q;
    assign ram_ack   = ack_q;
    assign rd_count  = rd_count_q;
    assign wr_count  = wr_count_q;
endmodule

// File: tb/tb_ram_model.sv
// Self-checking bench for ram_model: LATENCY=4, LATENCY=2 and a 4-bit counter build
// share one request stream; read words are scored in order through an expected queue.
module tb_ram_model;
    localparam int AW = 13;
    localparam int WW = 16;

    typedef struct {
        logic          rnw;
        logic [AW-1:0] addr;
        logic [WW-1:0] wdata;
        logic [WW-1:0] exp_rdata;
    } vec_t;

    logic          clk = 1'b0;
    logic          ram_rst;
    logic [AW-1:0] ram_addr;
    logic [WW-1:0] ram_wdata;
    logic          ram_avalid;
    logic          ram_rnw;
    logic          avalid_c;

    logic [WW-1:0] rdata4, rdata2, rdatac;
    logic          ack4, ack2, ackc;
    logic [15:0]   rd_count4, wr_count4, rd_count2, wr_count2;
    logic [3:0]    rd_countc, wr_countc;

    int            checks = 0;
    int            failures = 0;
    int            rd_model = 0;
    int            wr_model = 0;
    logic [WW-1:0] exp_hist[$];
    int            head4 = 0;
    int            head2 = 0;
    logic [WW-1:0] prev4, prev2;
    logic          rst_s;
    logic          ack_seen_c = 1'b0;

    vec_t          vec[16];
    logic [WW-1:0] burst_words[4];

    always #5 clk = ~clk;

    // The counter-wrap instance only ever sees writes, so it must never ack.
    assign avalid_c = ram_avalid & ~ram_rnw;

    ram_model #(.ADDR_SIZE(AW), .WORD_SIZE(WW), .LATENCY(4), .CNT_WIDTH(16)) dut (
        .ram_clk(clk), .ram_rst(ram_rst), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_avalid(ram_avalid), .ram_rnw(ram_rnw), .ram_rdata(rdata4), .ram_ack(ack4),
        .rd_count(rd_count4), .wr_count(wr_count4)
    );

    ram_model #(.ADDR_SIZE(AW), .WORD_SIZE(WW), .LATENCY(2), .CNT_WIDTH(16)) dut_l2 (
        .ram_clk(clk), .ram_rst(ram_rst), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_avalid(ram_avalid), .ram_rnw(ram_rnw), .ram_rdata(rdata2), .ram_ack(ack2),
        .rd_count(rd_count2), .wr_count(wr_count2)
    );

    ram_model #(.ADDR_SIZE(AW), .WORD_SIZE(WW), .LATENCY(4), .CNT_WIDTH(4)) dut_c4 (
        .ram_clk(clk), .ram_rst(ram_rst), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_avalid(avalid_c), .ram_rnw(ram_rnw), .ram_rdata(rdatac), .ram_ack(ackc),
        .rd_count(rd_countc), .wr_count(wr_countc)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drives one request on the falling edge and records what the model expects of it.
    task automatic applyStimulus(input logic do_rst, input logic do_valid, input logic do_rnw,
                                 input logic [AW-1:0] a, input logic [WW-1:0] wd,
                                 input logic [WW-1:0] exp_word);
        @(negedge clk);
        ram_rst    = do_rst;
        ram_avalid = do_valid;
        ram_rnw    = do_rnw;
        ram_addr   = a;
        ram_wdata  = wd;
        if (do_rst) begin
            rd_model = 0;
            wr_model = 0;
        end else if (do_valid) begin
            if (do_rnw) begin
                exp_hist.push_back(exp_word);
                rd_model++;
            end else begin
                wr_model++;
            end
        end
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b0, 1'($urandom), AW'($urandom), WW'($urandom), '0);
        end
    endtask

    // Interface-style capture: the word registered one edge before an ack is the one scored.
    always @(posedge clk) begin
        rst_s = ram_rst;
        #1;
        if (rst_s) begin
            head4 = exp_hist.size();
            head2 = exp_hist.size();
        end else begin
            if (ack4) begin
                if (head4 >= exp_hist.size()) checkOutput("ack4_unexpected", 32'(ack4), 0);
                else begin
                    checkOutput("ack4_word", 32'(prev4), 32'(exp_hist[head4]));
                    head4++;
                end
            end
            if (ack2) begin
                if (head2 >= exp_hist.size()) checkOutput("ack2_unexpected", 32'(ack2), 0);
                else begin
                    checkOutput("ack2_word", 32'(prev2), 32'(exp_hist[head2]));
                    head2++;
                end
            end
        end
        if (ackc) ack_seen_c = 1'b1;
        prev4 = rdata4;
        prev2 = rdata2;
    end

    initial begin
        int s;

        vec[0]  = '{1'b0, 13'h100, 16'h1111, 16'h0000};
        vec[1]  = '{1'b0, 13'h101, 16'h2222, 16'h0000};
        vec[2]  = '{1'b0, 13'h102, 16'h3333, 16'h0000};
        vec[3]  = '{1'b0, 13'h103, 16'h4444, 16'h0000};
        vec[4]  = '{1'b1, 13'h100, 16'h0000, 16'h1111};
        vec[5]  = '{1'b1, 13'h101, 16'h0000, 16'h2222};
        vec[6]  = '{1'b1, 13'h102, 16'h0000, 16'h3333};
        vec[7]  = '{1'b1, 13'h103, 16'h0000, 16'h4444};
        vec[8]  = '{1'b0, 13'h010, 16'hAAAA, 16'h0000};
        vec[9]  = '{1'b1, 13'h010, 16'h0000, 16'hAAAA};
        vec[10] = '{1'b0, 13'h010, 16'h5555, 16'h0000};
        vec[11] = '{1'b1, 13'h010, 16'h0000, 16'h5555};
        vec[12] = '{1'b0, 13'h1FFF, 16'hFFFF, 16'h0000};
        vec[13] = '{1'b0, 13'h000, 16'h0001, 16'h0000};
        vec[14] = '{1'b1, 13'h1FFF, 16'h0000, 16'hFFFF};
        vec[15] = '{1'b1, 13'h000, 16'h0000, 16'h0001};
        burst_words[0] = 16'h1111;
        burst_words[1] = 16'h2222;
        burst_words[2] = 16'h3333;
        burst_words[3] = 16'h4444;

        ram_rst = 1'b1; ram_avalid = 1'b0; ram_rnw = 1'b0; ram_addr = '0; ram_wdata = '0;
        applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, '0);
        applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, '0);
        idleCycles(1);
        checkOutput("reset_ack4", 32'(ack4), 0);
        checkOutput("reset_rdata4", 32'(rdata4), 0);
        checkOutput("reset_rd_count4", 32'(rd_count4), 0);
        checkOutput("reset_wr_count4", 32'(wr_count4), 0);
        checkOutput("reset_rdata2", 32'(rdata2), 0);
        checkOutput("reset_wr_countc", 32'(wr_countc), 0);

        // Single write then read: step s observes the state after edge t+s.
        applyStimulus(1'b0, 1'b1, 1'b0, 13'h005, 16'hBEEF, '0);
        idleCycles(2);
        applyStimulus(1'b0, 1'b1, 1'b1, 13'h005, '0, 16'hBEEF);
        for (int step = 0; step < 6; step++) begin
            idleCycles(1);
            checkOutput($sformatf("single_rdata4_s%0d", step), 32'(rdata4), (step >= 3) ? 32'hBEEF : 0);
            checkOutput($sformatf("single_ack4_s%0d", step), 32'(ack4), (step == 4) ? 1 : 0);
            checkOutput($sformatf("single_rdata2_s%0d", step), 32'(rdata2), (step >= 1) ? 32'hBEEF : 0);
            checkOutput($sformatf("single_ack2_s%0d", step), 32'(ack2), (step == 2) ? 1 : 0);
        end
        checkOutput("single_rd_count4", 32'(rd_count4), 32'(rd_model));
        checkOutput("single_wr_count4", 32'(wr_count4), 32'(wr_model));
        checkOutput("single_rd_count2", 32'(rd_count2), 32'(rd_model));

        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 1'b1, vec[i].rnw, vec[i].addr, vec[i].wdata, vec[i].exp_rdata);
        end
        idleCycles(8);
        checkOutput("table_rd_count4", 32'(rd_count4), 32'(rd_model));
        checkOutput("table_wr_count4", 32'(wr_count4), 32'(wr_model));
        checkOutput("table_wr_countc", 32'(wr_countc), 32'(wr_model % 16));

        // 32 back-to-back reads: acks must be contiguous for both latencies.
        for (int k = 0; k < 38; k++) begin
            if (k < 32)
                applyStimulus(1'b0, 1'b1, 1'b1, 13'h100 + AW'(k % 4), WW'($urandom), burst_words[k % 4]);
            else
                idleCycles(1);
            if (k >= 1) begin
                s = k - 1;
                checkOutput($sformatf("burst_ack4_s%0d", s), 32'(ack4), (s >= 4 && s <= 35) ? 1 : 0);
                checkOutput($sformatf("burst_ack2_s%0d", s), 32'(ack2), (s >= 2 && s <= 33) ? 1 : 0);
            end
        end

        // Reset two cycles after the first of three reads; the third read coincides with reset.
        applyStimulus(1'b0, 1'b1, 1'b1, 13'h100, '0, 16'h1111);
        applyStimulus(1'b0, 1'b1, 1'b1, 13'h101, '0, 16'h2222);
        applyStimulus(1'b1, 1'b1, 1'b1, 13'h102, '0, 16'h3333);
        idleCycles(1);
        checkOutput("midrst_ack4", 32'(ack4), 0);
        checkOutput("midrst_ack2", 32'(ack2), 0);
        checkOutput("midrst_rdata4", 32'(rdata4), 0);
        checkOutput("midrst_rdata2", 32'(rdata2), 0);
        checkOutput("midrst_rd_count4", 32'(rd_count4), 0);
        checkOutput("midrst_wr_count4", 32'(wr_count4), 0);
        idleCycles(6);
        applyStimulus(1'b1, 1'b1, 1'b0, 13'h005, 16'h0000, '0);
        idleCycles(1);
        applyStimulus(1'b0, 1'b1, 1'b1, 13'h005, '0, 16'hBEEF);
        applyStimulus(1'b0, 1'b1, 1'b1, 13'h010, '0, 16'h5555);
        idleCycles(8);
        checkOutput("post_rst_rd_count4", 32'(rd_count4), 32'(rd_model));
        checkOutput("post_rst_wr_count4", 32'(wr_count4), 32'(wr_model));

        applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, '0);
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 13'h200 + AW'(i), WW'(i), '0);
        end
        idleCycles(2);
        checkOutput("wrap_wr_countc", 32'(wr_countc), 32'(wr_model % 16));
        checkOutput("wrap_rd_countc", 32'(rd_countc), 0);
        checkOutput("wrap_wr_count4", 32'(wr_count4), 32'(wr_model));

        checkOutput("c4_never_acked", 32'(ack_seen_c), 0);
        checkOutput("drained_head4", 32'(head4), 32'(exp_hist.size()));
        checkOutput("drained_head2", 32'(head2), 32'(exp_hist.size()));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
